pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, number of cycles btt_out is held asserted per pulse; legal range 1..256.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, minimum number of deasserted cycles between consecutive holds; legal range 1..256.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port pulse_in  input  1  single-cycle request, active-high, synchronous to clk.
REQ-006 SHALL have port btt_out  output  1  stretched press, active-low, registered.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE, registered.
REQ-008 SHALL have port pend_cnt  output  4  number of queued requests not yet replayed.
REQ-009 SHALL have port ovf  output  1  sticky flag: a request was lost.

Function
REQ-010 SHALL implement a state machine with states IDLE, HOLD and GAP, plus an 8-bit down-counter tmr.
REQ-011 IDLE: if pulse_in=1, SHALL go to HOLD and load tmr=HOLD_CYCLES-1; otherwise SHALL stay in IDLE.
REQ-012 HOLD: tmr SHALL decrement each cycle; at tmr=0 the block SHALL go to GAP and load tmr=GAP_CYCLES-1.
REQ-013 GAP: tmr SHALL decrement each cycle; at tmr=0 the block SHALL go to HOLD (reloading HOLD_CYCLES-1) if pend_cnt>0 or pulse_in=1, and SHALL go to IDLE otherwise.
REQ-014 btt_out SHALL be 0 exactly while state=HOLD and 1 in all other states.
REQ-015 Latency: pulse_in sampled high at edge n while IDLE SHALL give btt_out=0 from edge n+1 for exactly HOLD_CYCLES cycles.
REQ-016 busy SHALL equal (state != IDLE).
REQ-017 A pulse_in in HOLD, or in GAP with tmr!=0, SHALL be handled per REQ-026/REQ-027.
REQ-018 At the GAP-end decision (REQ-013), a simultaneous pulse_in with pend_cnt>0 SHALL leave pend_cnt unchanged (one replayed, one queued); with pend_cnt=0, pulse_in SHALL be consumed directly.
REQ-019 At the GAP-end decision, pend_cnt>0 without pulse_in SHALL decrement pend_cnt by 1.
REQ-020 pend_cnt SHALL saturate at 15; a request arriving at 15 SHALL leave pend_cnt=15 and set ovf=1.
REQ-021 Once set, ovf SHALL stay 1 until reset.
REQ-022 Unreachable state encodings SHALL return to IDLE on the next edge with btt_out=1.

Reset
REQ-023 On reset=0 at a clk edge: state=IDLE, tmr=0, btt_out=1, busy=0, pend_cnt=0, ovf=0.
REQ-024 Reset asserted mid-HOLD SHALL release btt_out to 1 on that edge and discard all queued requests; pulse_in during reset SHALL be ignored.
REQ-025 The first pulse_in accepted SHALL be one sampled on the first edge with reset=1.

Configuration
REQ-026 With macro PULSE_STRETCH_QUEUE_EN defined, requests per REQ-017 SHALL increment pend_cnt (saturating) and be replayed in order per REQ-013/REQ-019.
REQ-027 Without PULSE_STRETCH_QUEUE_EN, requests per REQ-017 SHALL be dropped and set ovf=1, pend_cnt SHALL be constant 0, and GAP end SHALL depend on pulse_in only.

Structure
REQ-028 Package pulse_stretch_pkg SHALL hold the state enum (IDLE, HOLD, GAP), PEND_W=4, PEND_MAX=15 and TMR_W=8.
REQ-029 Sub-module stretch_timer SHALL be a loadable 8-bit down-counter (load, value, en, zero flag), instantiated once.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2 unless noted)
REQ-030 Single pulse at edge 10 -> btt_out=0 at edges 11-14, 1 from edge 15; busy=1 at edges 11-16; back to IDLE at edge 17.
REQ-031 QUEUE_EN: pulses at edges 10, 12 and 13 -> pend_cnt=2 by edge 14; three holds start at edges 11, 17 and 23; pend_cnt=0 at edge 23.
REQ-032 QUEUE_EN: 17 pulses during one HOLD (HOLD_CYCLES=32) -> pend_cnt=15, ovf=1; ovf stays 1 after the queue drains.
REQ-033 Without QUEUE_EN: pulses at edges 10 and 12 -> exactly one hold (edges 11-14), ovf=1 from edge 13, pend_cnt=0 throughout.
REQ-034 Reset=0 at edge 12, mid-hold with pend_cnt=3 -> btt_out=1, pend_cnt=0, ovf=0, busy=0 at edge 12; no replay follows.
REQ-035 Boundaries HOLD_CYCLES=1, GAP_CYCLES=1 with back-to-back pulses every edge: btt_out alternates 0,1 each cycle while pulses continue; the simultaneous GAP-end pulse is consumed per REQ-018.

Source files
------------

// File: rtl/pulse_stretch_pkg.sv
// Shared state encoding, widths and the saturating queue helper for the pulse stretcher.
package pulse_stretch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int PEND_W   = 4;
   localparam int PEND_MAX = 15;
   localparam int TMR_W    = 8;

   // Count up one queued request, sticking at the ceiling.
   function automatic logic [PEND_W-1:0] pend_sat_inc(input logic [PEND_W-1:0] v);
      return (v == PEND_W'(PEND_MAX)) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/stretch_timer.sv
// Loadable down-counter that paces the hold and gap phases; load wins over enable.
module stretch_timer
   import pulse_stretch_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [TMR_W-1:0] value,
   input  logic             en,
   output logic             zero
);

   logic [TMR_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= value;
      end else if (en && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle requests into active-low holds separated by a minimum gap.
// Build option PULSE_STRETCH_QUEUE_EN: requests arriving while busy are queued and replayed.
module pulse_stretcher
   import pulse_stretch_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              pulse_in,
   output logic              btt_out,
   output logic              busy,
   output logic [PEND_W-1:0] pend_cnt,
   output logic              ovf
);

   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

   state_t           state_reg;
   state_t           state_next;
   logic             tmr_load;
   logic             tmr_en;
   logic             tmr_zero;
   logic [TMR_W-1:0] tmr_value;
   logic             queue_req;
   logic             has_pend;
   logic             ovf_reg;

   assign has_pend = (pend_cnt != '0);

   stretch_timer u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tmr_load),
      .value (tmr_value),
      .en    (tmr_en),
      .zero  (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         btt_out   <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state_reg <= state_next;
         btt_out   <= (state_reg != HOLD);
         busy      <= (state_reg != IDLE);
      end
   end

   always_comb begin
      state_next = state_reg;
      tmr_load   = 1'b0;
      tmr_value  = HOLD_LOAD;
      tmr_en     = 1'b0;
      queue_req  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pulse_in) begin
               state_next = HOLD;
               tmr_load   = 1'b1;
            end
         end
         HOLD: begin
            queue_req = pulse_in;
            if (tmr_zero) begin
               state_next = GAP;
               tmr_load   = 1'b1;
               tmr_value  = GAP_LOAD;
            end else begin
               tmr_en = 1'b1;
            end
         end
         GAP: begin
            if (tmr_zero) begin
               // A pulse landing on the gap end starts the next hold directly.
               if (has_pend || pulse_in) begin
                  state_next = HOLD;
                  tmr_load   = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               tmr_en    = 1'b1;
               queue_req = pulse_in;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef PULSE_STRETCH_QUEUE_EN
   logic [PEND_W-1:0] pend_reg;
   logic              pend_dec;

   // A replay without a simultaneous pulse consumes one queued entry; with a pulse the count nets out.
   assign pend_dec = (state_reg == GAP) && tmr_zero && !pulse_in;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_reg <= '0;
         ovf_reg  <= 1'b0;
      end else if (queue_req) begin
         if (pend_reg == PEND_W'(PEND_MAX)) begin
            ovf_reg <= 1'b1;
         end
         pend_reg <= pend_sat_inc(pend_reg);
      end else if (pend_dec && (pend_reg != '0)) begin
         pend_reg <= pend_reg - 1'b1;
      end
   end

   assign pend_cnt = pend_reg;
`else
   always_ff @(posedge clk) begin
      if (!reset) begin
         ovf_reg <= 1'b0;
      end else if (queue_req) begin
         ovf_reg <= 1'b1;
      end
   end

   assign pend_cnt = '0;
`endif

   assign ovf = ovf_reg;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: three instances cover default, minimum and long hold timing.
module tb_pulse_stretcher;

`ifdef PULSE_STRETCH_QUEUE_EN
   localparam bit QEN = 1'b1;
`else
   localparam bit QEN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       p_main, p_min, p_long;
   logic       btt_main, busy_main, ovf_main;
   logic       btt_min, busy_min, ovf_min;
   logic       btt_long, busy_long, ovf_long;
   logic [3:0] pend_main, pend_min, pend_long;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2)) u_main (
      .clk(clk), .reset(reset), .pulse_in(p_main), .btt_out(btt_main),
      .busy(busy_main), .pend_cnt(pend_main), .ovf(ovf_main));

   pulse_stretcher #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) u_min (
      .clk(clk), .reset(reset), .pulse_in(p_min), .btt_out(btt_min),
      .busy(busy_min), .pend_cnt(pend_min), .ovf(ovf_min));

   pulse_stretcher #(.HOLD_CYCLES(32), .GAP_CYCLES(2)) u_long (
      .clk(clk), .reset(reset), .pulse_in(p_long), .btt_out(btt_long),
      .busy(busy_long), .pend_cnt(pend_long), .ovf(ovf_long));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask

   initial begin
      int exp_pend;
      reset  = 1'b0;
      p_main = 1'b1;
      p_min  = 1'b1;
      p_long = 1'b1;
      tick(3);
      $display("reset state with pulses held high");
      check("rst_btt",  btt_main,  1);
      check("rst_busy", busy_main, 0);
      check("rst_pend", pend_main, 0);
      check("rst_ovf",  ovf_main,  0);
      check("rst_busy_min",  busy_min,  0);
      check("rst_busy_long", busy_long, 0);
      p_main = 1'b0; p_min = 1'b0; p_long = 1'b0;
      reset  = 1'b1;
      tick(3);
      check("rst_ignored_busy", busy_main, 0);

      // single pulse at edge 10
      for (int e = 1; e <= 20; e++) begin
         p_main = (e == 10);
         tick(1);
         check($sformatf("single_btt@%0d", e),  btt_main,  !(e >= 11 && e <= 14));
         check($sformatf("single_busy@%0d", e), busy_main, (e >= 11 && e <= 16));
      end
      $display("single pulse done");

      // pulse on the very first edge out of reset is accepted
      reset = 1'b0;
      tick(2);
      reset  = 1'b1;
      p_main = 1'b1;
      for (int e = 0; e <= 6; e++) begin
         tick(1);
         p_main = 1'b0;
         check($sformatf("first_edge_btt@%0d", e), btt_main, !(e >= 1 && e <= 4));
      end
      $display("first-edge pulse done");

      // pulses at edges 10, 12, 13
      do_reset();
      for (int e = 1; e <= 32; e++) begin
         p_main = (e == 10 || e == 12 || e == 13);
         tick(1);
         if (QEN)
            check($sformatf("burst_btt@%0d", e), btt_main,
                  !((e >= 11 && e <= 14) || (e >= 17 && e <= 20) || (e >= 23 && e <= 26)));
         else
            check($sformatf("burst_btt@%0d", e), btt_main, !(e >= 11 && e <= 14));
         if (e == 11) check("burst_ovf@11", ovf_main, 0);
         if (e == 13) check("burst_ovf@13", ovf_main, QEN ? 0 : 1);
         if (e == 14) check("burst_pend@14", pend_main, QEN ? 2 : 0);
         if (e == 16) check("burst_pend@16", pend_main, QEN ? 1 : 0);
         if (e == 23) check("burst_pend@23", pend_main, 0);
         if (e == 32) check("burst_busy@32", busy_main, 0);
         if (e == 32) check("burst_ovf@32",  ovf_main, QEN ? 0 : 1);
      end
      $display("burst pulses done");

      // reset mid-hold with queued requests
      do_reset();
      for (int e = 1; e <= 11; e++) begin
         p_main = (e >= 8);
         tick(1);
      end
      check("midrst_pend@11", pend_main, QEN ? 3 : 0);
      check("midrst_ovf@11",  ovf_main,  QEN ? 0 : 1);
      check("midrst_btt@11",  btt_main,  0);
      reset  = 1'b0;
      p_main = 1'b1;
      tick(1);
      check("midrst_btt@12",  btt_main,  1);
      check("midrst_pend@12", pend_main, 0);
      check("midrst_ovf@12",  ovf_main,  0);
      check("midrst_busy@12", busy_main, 0);
      reset  = 1'b1;
      p_main = 1'b0;
      for (int e = 13; e <= 24; e++) begin
         tick(1);
         check($sformatf("midrst_btt@%0d", e),  btt_main,  1);
         check($sformatf("midrst_busy@%0d", e), busy_main, 0);
      end
      $display("mid-hold reset done");

      // HOLD=1, GAP=1 with a pulse on every edge 1..10
      do_reset();
      for (int e = 1; e <= 24; e++) begin
         p_min = (e <= 10);
         tick(1);
         if (QEN) begin
            if (e <= 10) exp_pend = e / 2;
            else exp_pend = ((5 - (e - 9) / 2) > 0) ? (5 - (e - 9) / 2) : 0;
            check($sformatf("min_btt@%0d", e), btt_min, !((e % 2 == 0) && e <= 20));
            check($sformatf("min_pend@%0d", e), pend_min, exp_pend);
            check($sformatf("min_ovf@%0d", e), ovf_min, 0);
         end else begin
            check($sformatf("min_btt@%0d", e), btt_min, !((e % 2 == 0) && e <= 10));
            check($sformatf("min_pend@%0d", e), pend_min, 0);
            check($sformatf("min_ovf@%0d", e), ovf_min, (e >= 2));
         end
      end
      check("min_busy_end", busy_min, 0);
      $display("minimum timing done");

      // HOLD=32: 17 extra pulses during one hold
      do_reset();
      for (int e = 1; e <= 20; e++) begin
         p_long = (e <= 18);
         tick(1);
         if (e == 15) check("long_pend@15", pend_long, QEN ? 14 : 0);
         if (e == 15) check("long_ovf@15",  ovf_long,  QEN ? 0 : 1);
         if (e == 16) check("long_pend@16", pend_long, QEN ? 15 : 0);
         if (e == 17) check("long_ovf@17",  ovf_long,  1);
         if (e == 20) check("long_pend@20", pend_long, QEN ? 15 : 0);
         if (e == 20) check("long_btt@20",  btt_long,  0);
      end
      tick(700);
      check("long_drain_pend", pend_long, 0);
      check("long_drain_busy", busy_long, 0);
      check("long_drain_btt",  btt_long,  1);
      check("long_drain_ovf",  ovf_long,  1);
      $display("long hold saturation done");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
